// File: rtl/svm_slice_acc.sv
// Per-window slice accumulator: sums NSLICE partial dot products per window,
// adds a bias on the final slice, and emits a saturated score with detect flag.
module svm_slice_acc #(
    parameter int NWIN   = 64,
    parameter int NSLICE = 4,
    parameter int IWIDTH = 32,
    parameter int SWIDTH = 40,
    localparam int IW = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int SW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     dvi,
    input  logic signed [IWIDTH-1:0] svm_data,
    input  logic signed [IWIDTH-1:0] bias,
    input  logic                     clear,
    output logic signed [SWIDTH-1:0] score,
    output logic [IW-1:0]            win_idx,
    output logic                     dvo,
    output logic                     detect,
    output logic                     frame_done,
    output logic [SW-1:0]            slice_idx
);

    typedef enum logic {ACCUM, EMIT} state_t;

    function automatic logic signed [SWIDTH-1:0] sat_add(
        input logic signed [SWIDTH-1:0] a,
        input logic signed [SWIDTH-1:0] b
    );
        logic signed [SWIDTH:0] s;
        s = {a[SWIDTH-1], a} + {b[SWIDTH-1], b};
        if (s[SWIDTH] != s[SWIDTH-1])
            sat_add = s[SWIDTH] ? {1'b1, {(SWIDTH-1){1'b0}}} : {1'b0, {(SWIDTH-1){1'b1}}};
        else
            sat_add = s[SWIDTH-1:0];
    endfunction

    function automatic logic signed [SWIDTH-1:0] sext(input logic signed [IWIDTH-1:0] v);
        sext = {{(SWIDTH-IWIDTH){v[IWIDTH-1]}}, v};
    endfunction

    logic signed [SWIDTH-1:0] acc [NWIN];
    logic [IW-1:0]            idx, idx_nxt;
    logic [SW-1:0]            slice, slice_nxt;
    state_t                   state;
    logic                     accept;
    logic                     last_win;
    logic signed [SWIDTH-1:0] base, sum_p0, result_p0;

    logic signed [SWIDTH-1:0] score_p1;
    logic [IW-1:0]            win_p1;
    logic                     vld_p1, detect_p1, fdone_p1;

    assign accept   = dvi && !clear;
    assign last_win = (idx == IW'(NWIN - 1));

    // Stage 0: counter next-state and saturating sums from the current slice state
    always_comb begin
        state     = (slice == SW'(NSLICE - 1)) ? EMIT : ACCUM;
        idx_nxt   = idx;
        slice_nxt = slice;
        if (clear) begin
            idx_nxt   = '0;
            slice_nxt = '0;
        end else if (dvi) begin
            if (last_win) begin
                idx_nxt   = '0;
                slice_nxt = (state == EMIT) ? '0 : slice + SW'(1);
            end else begin
                idx_nxt = idx + IW'(1);
            end
        end
    end

    always_comb begin
        base      = (slice == '0) ? '0 : acc[idx];
        sum_p0    = sat_add(base, sext(svm_data));
        result_p0 = sat_add(sum_p0, sext(bias));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            slice <= '0;
        end else begin
            idx   <= idx_nxt;
            slice <= slice_nxt;
        end
    end

    // Partial sums are overwritten by slice 0, so the array needs no reset
    always_ff @(posedge clk) begin
        if (accept && state == ACCUM)
            acc[idx] <= sum_p0;
    end

    // Stage 1: registered score and flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_p1  <= '0;
            win_p1    <= '0;
            vld_p1    <= 1'b0;
            detect_p1 <= 1'b0;
            fdone_p1  <= 1'b0;
        end else begin
            vld_p1   <= accept && state == EMIT;
            fdone_p1 <= accept && state == EMIT && last_win;
            if (accept && state == EMIT) begin
                score_p1  <= result_p0;
                win_p1    <= idx;
                detect_p1 <= !result_p0[SWIDTH-1] && (result_p0 != '0);
            end
        end
    end

    assign score      = score_p1;
    assign win_idx    = win_p1;
    assign dvo        = vld_p1;
    assign detect     = detect_p1;
    assign frame_done = fdone_p1;
    assign slice_idx  = slice;

endmodule
